// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding halfword reads into a small FIFO feeding decode.
// Optional IFETCH_PERF_EN adds saturating perf_fetched / perf_flushed counters.
module instr_fetch #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [15:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);

    localparam int unsigned       PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned       CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     FULL    = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_n;
    logic [ADDR_W-1:0] issue_pc_q, issue_pc_n;

    logic [15:0]       data_q [DEPTH];
    logic [15:0]       data_n [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_n   [DEPTH];
    logic [PW-1:0]     rd_q, rd_n, wr_q, wr_n;
    logic [CW-1:0]     cnt_q, cnt_n;

    logic push, pop;

    assign imem_addr = fetch_pc_q;

    always_comb begin
        state_n    = state_q;
        fetch_pc_n = fetch_pc_q;
        issue_pc_n = issue_pc_q;
        push       = 1'b0;
        pop        = instr_valid && instr_ready && !redirect;

        case (state_q)
            S_IDLE: begin
                if (redirect || (cnt_q < FULL)) state_n = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt) begin
                    issue_pc_n = fetch_pc_q;
                    fetch_pc_n = fetch_pc_q + PC_STEP;
                    state_n    = redirect ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        state_n = S_REQ;
                    end else begin
                        push    = 1'b1;
                        // Space after this cycle's push and pop decides whether to fetch again
                        state_n = ((cnt_q + CW'(1) - CW'(pop)) < FULL) ? S_REQ : S_IDLE;
                    end
                end else if (redirect) begin
                    state_n = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_n = S_REQ;
            end
            default: state_n = S_IDLE;
        endcase

        if (redirect) fetch_pc_n = redirect_pc & PC_MASK;
    end

    always_comb begin
        data_n = data_q;
        pc_n   = pc_q;
        rd_n   = rd_q;
        wr_n   = wr_q;
        cnt_n  = cnt_q;
        if (redirect) begin
            cnt_n = '0;
            rd_n  = wr_q;
        end else begin
            if (push) begin
                data_n[wr_q] = imem_rdata;
                pc_n[wr_q]   = issue_pc_q;
                wr_n         = wr_q + PW'(1);
            end
            if (pop) rd_n = rd_q + PW'(1);
            cnt_n = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Head outputs are registered from the next-state FIFO view, so a push lands one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC & PC_MASK;
            issue_pc_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instruction <= '0;
            instr_pc    <= '0;
        end else begin
            state_q     <= state_n;
            fetch_pc_q  <= fetch_pc_n;
            issue_pc_q  <= issue_pc_n;
            data_q      <= data_n;
            pc_q        <= pc_n;
            rd_q        <= rd_n;
            wr_q        <= wr_n;
            cnt_q       <= cnt_n;
            imem_req    <= (state_n == S_REQ);
            instr_valid <= (cnt_n != '0);
            instruction <= data_n[rd_n];
            instr_pc    <= pc_n[rd_n];
        end
    end

`ifdef IFETCH_PERF_EN
    logic flush_hit;
    assign flush_hit = redirect && ((cnt_q != '0) || (state_q == S_WAIT) ||
                                    (state_q == S_DROP) || ((state_q == S_REQ) && imem_gnt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
            if (flush_hit && (perf_flushed != '1)) perf_flushed <= perf_flushed + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder, stream-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [15:0] instruction;
    logic [15:0] instr_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(16), .DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .instr_pc    (instr_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory: answers a granted read after 'lat' cycles with 16'h1800 | addr
    int unsigned lat = 1;
    int unsigned resp_cnt = 0;
    logic [15:0] resp_addr = '0;
    bit          dead_en = 1'b0;
    logic [15:0] dead_addr = '0;

    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (imem_req && imem_gnt) begin
            resp_addr = imem_addr;
            resp_cnt  = lat;
        end
        if (resp_cnt == 1) begin
            resp_cnt = 0;
            imem_rvalid <= 1'b1;
            imem_rdata  <= (dead_en && resp_addr == dead_addr) ? 16'hDEAD : (16'h1800 | resp_addr);
        end else if (resp_cnt > 1) begin
            resp_cnt--;
        end
    end

    // Reference: decode sees consecutive halfwords from the last reset/redirect target, in order
    logic [15:0] exp_pc = '0;
    logic [15:0] exp_fetch = '0;
    logic [15:0] prev_addr = '0;
    bit          prev_hold = 1'b0;
    bit          prev_redir = 1'b0;
    bit          chk_outst = 1'b1;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc     = 16'h0000;
            exp_fetch  = 16'h0000;
            prev_hold  = 1'b0;
            prev_redir = 1'b0;
        end else begin
            check("addr_lsb", imem_addr[0], 1'b0);
            if (prev_hold) begin
                check("req_held", imem_req, 1'b1);
                check("addr_held", imem_addr, prev_addr);
            end
            if (prev_redir) check("flush_valid", instr_valid, 1'b0);
            if (chk_outst && (resp_cnt != 0 || imem_rvalid)) check("one_outstanding", imem_req, 1'b0);
            if (imem_req && imem_gnt) begin
                check("fetch_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 16'd2;
            end
            if (instr_valid) begin
                check("head_pc", instr_pc, exp_pc);
                check("head_instr", instruction, 16'h1800 | exp_pc);
                if (instr_ready && !redirect) exp_pc = exp_pc + 16'd2;
            end
            if (redirect) begin
                exp_pc    = redirect_pc & 16'hFFFE;
                exp_fetch = exp_pc;
            end
            prev_hold  = imem_req && !imem_gnt && !redirect;
            prev_addr  = imem_addr;
            prev_redir = redirect;
        end
    end

    task automatic reset_dut;
        tick;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int          first_gnt;
        int          first_val;
        int          n_got;
        bit          found;
        bit          seen_gnt;
        logic [15:0] got_instr [3];
        logic [15:0] got_pc [3];

        // Reset values while rst_n is held low from time zero
        #2;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instruction, 16'h0000);
        check("rst_pc", instr_pc, 16'h0000);

        // Streaming: gnt always, rvalid one cycle after gnt, decode always ready
        tick;
        tick;
        rst_n = 1'b1;
        first_gnt = -1;
        first_val = -1;
        n_got = 0;
        for (int i = 0; i < 40 && n_got < 3; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt && first_gnt < 0) first_gnt = i;
            if (instr_valid && first_val < 0) first_val = i;
            if (instr_valid && instr_ready) begin
                got_instr[n_got] = instruction;
                got_pc[n_got]    = instr_pc;
                n_got++;
            end
        end
        check("stream_count", n_got, 3);
        check("first_gnt_cycle", first_gnt, 1);
        check("gnt_to_valid", first_val - first_gnt, 2);
        if (n_got == 3) begin
            check("stream_i0", got_instr[0], 16'h1800);
            check("stream_i1", got_instr[1], 16'h1802);
            check("stream_i2", got_instr[2], 16'h1804);
            check("stream_p0", got_pc[0], 16'h0000);
            check("stream_p1", got_pc[1], 16'h0002);
            check("stream_p2", got_pc[2], 16'h0004);
        end

        // Back-pressure: FIFO fills with pc 0 and 2, then fetching stops
        instr_ready = 1'b0;
        reset_dut;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 6) check("full_req_low", imem_req, 1'b0);
        end
        check("full_valid", instr_valid, 1'b1);
        check("full_head_pc", instr_pc, 16'h0000);
        check("full_head_instr", instruction, 16'h1800);
        tick;
        instr_ready = 1'b1;
        @(negedge clk);
        tick;
        @(negedge clk);
        check("drain_valid", instr_valid, 1'b1);
        check("drain_pc", instr_pc, 16'h0002);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                found = 1'b1;
                check("resume_addr", imem_addr, 16'h0004);
            end
        end
        check("resume_seen", found, 1'b1);

        // Grant stall: request and address hold at 0x0006
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick;
            if (imem_req && imem_addr == 16'h0006) found = 1'b1;
        end
        check("stall_reach", found, 1'b1);
        imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req", imem_req, 1'b1);
            check("stall_addr", imem_addr, 16'h0006);
        end
        tick;
        imem_gnt = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == 16'h0006) begin
                found = 1'b1;
                check("stall_instr", instruction, 16'h1806);
            end
        end
        check("stall_done", found, 1'b1);

        // Redirect while waiting: the stale response (0xDEAD) must be dropped
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick;
            if (resp_cnt != 0) found = 1'b1;
        end
        check("wait_reach", found, 1'b1);
        dead_addr   = resp_addr;
        dead_en     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0043;
        lat = 1;
        tick;
        redirect = 1'b0;
        @(negedge clk);
        check("redir_addr", imem_addr, 16'h0042);
        check("redir_valid", instr_valid, 1'b0);
        check("redir_drop_req", imem_req, 1'b0);
        found = 1'b0;
        seen_gnt = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt && !seen_gnt) begin
                seen_gnt = 1'b1;
                check("redir_fetch", imem_addr, 16'h0042);
            end
            if (instr_valid) begin
                found = 1'b1;
                check("redir_instr", instruction, 16'h1842);
                check("redir_pc", instr_pc, 16'h0042);
            end
        end
        check("redir_done", found, 1'b1);
        dead_en = 1'b0;

        // Redirect together with a pop and a push that would fill the FIFO
        instr_ready = 1'b0;
        reset_dut;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick;
            if (imem_rvalid && instr_valid) found = 1'b1;
        end
        check("full_redir_reach", found, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        instr_ready = 1'b1;
        tick;
        redirect = 1'b0;
        @(negedge clk);
        check("fr_valid", instr_valid, 1'b0);
        check("fr_req", imem_req, 1'b1);
        check("fr_addr", imem_addr, 16'h0100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                found = 1'b1;
                check("fr_instr", instruction, 16'h1900);
                check("fr_pc", instr_pc, 16'h0100);
            end
        end
        check("fr_done", found, 1'b1);

        // Reset in WAIT; the response landing after release must be ignored
        lat = 4;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick;
            if (resp_cnt != 0) found = 1'b1;
        end
        check("rw_reach", found, 1'b1);
        chk_outst = 1'b0;
        imem_gnt  = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rw_req", imem_req, 1'b0);
        check("rw_addr", imem_addr, 16'h0000);
        check("rw_valid", instr_valid, 1'b0);
        check("rw_instr", instruction, 16'h0000);
        check("rw_pc", instr_pc, 16'h0000);
        tick;
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (imem_req) begin
                found = 1'b1;
                check("rw_restart_addr", imem_addr, 16'h0000);
            end
        end
        check("rw_restart", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (imem_rvalid) begin
                found = 1'b1;
                check("rw_late_req", imem_req, 1'b1);
            end
        end
        check("rw_late_seen", found, 1'b1);
        @(negedge clk);
        check("rw_late_valid", instr_valid, 1'b0);
        check("rw_late_hold", imem_req, 1'b1);
        tick;
        lat       = 1;
        imem_gnt  = 1'b1;
        chk_outst = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                found = 1'b1;
                check("rw_first_instr", instruction, 16'h1800);
                check("rw_first_pc", instr_pc, 16'h0000);
            end
        end
        check("rw_done", found, 1'b1);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage; producer end of the 16-bit `instruction` interface consumed by the decoder.
- Issues halfword reads to instruction memory and tracks the fetch PC.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles PC redirects from branch execution (B, B<cc>, BX) by flushing and refetching.

Parameters:
- ADDR_W, 16, width of fetch PC and memory address (byte address).
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- RESET_PC, 16'h0000, first fetch address after reset; bit 0 ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  read request.
- imem_addr  out  ADDR_W  request address; bit 0 always 0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  16  returned instruction.
- redirect  in  1  one-cycle pulse: flush, restart at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts head.
- instruction  out  16  FIFO head instruction, to decoder.
- instr_pc  out  ADDR_W  address of FIFO head.

Behaviour:
- Interface clocking: one clock (clk); reset is asynchronous, active-low (rst_n). All outputs registered.
- Reset values: imem_req=0, imem_addr=RESET_PC&~1, instr_valid=0, instruction=16'h0000, instr_pc=0. FIFO empty, fetch_pc=RESET_PC&~1, state IDLE.
- States:
  - IDLE: if (fifo_count < DEPTH), go to REQ next cycle with imem_req=1.
  - REQ: imem_req=1 and imem_addr held stable until imem_gnt. On gnt: deassert req, fetch_pc += 2 (wraps modulo 2^ADDR_W), go to WAIT.
  - WAIT: on imem_rvalid, push {rdata, issued addr} into the FIFO. Go to REQ if the FIFO has space after the push and pop, else IDLE.
  - DROP: waiting for a stale response. On imem_rvalid, discard the data and go to REQ at fetch_pc.
- Outstanding requests: at most one. Space check: fifo_count + outstanding ≤ DEPTH, so a response is never lost.
- Memory timing: imem_rvalid arrives at least 1 cycle after gnt. imem_rvalid outside WAIT/DROP is ignored.
- Latency: gnt at cycle N, rvalid at N+1, instr_valid=1 at N+2. Peak throughput is 1 instruction per 2 cycles.
- Pop: when instr_valid && instr_ready. The next entry appears the following cycle.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Redirect (highest priority, same edge):
  - Clears the FIFO, so instr_valid=0 next cycle.
  - Sets fetch_pc = redirect_pc & ~1.
  - Any pop or push in the same cycle is discarded.
  - From IDLE or REQ without gnt: next state REQ with the new address; the old request is withdrawn and not completed.
  - From REQ with gnt this cycle, or from WAIT without rvalid: next state DROP.
  - From WAIT with rvalid this cycle: the response is discarded; next state REQ.
  - Redirect while in DROP: stay in DROP and update fetch_pc.
- instr_ready while instr_valid=0: no effect.
- Reset mid-operation: immediate return to reset values. Any response arriving after release is ignored, since the state is IDLE/REQ with no outstanding request.
- Full FIFO: imem_req stays 0 and the head holds until a pop.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32-bit, increments on each pop handshake) and perf_flushed (32-bit, increments on each redirect that discards at least one FIFO entry or in-flight response).
  - Both counters saturate at all-ones and reset to 0.
- Undefined: no such ports, no counter logic.

Test Plan:
- Reset release, gnt=1 always, rvalid one cycle after gnt with rdata=16'h1800|addr, instr_ready=1: instructions 16'h1800, 16'h1802, 16'h1804 delivered with instr_pc 0, 2, 4; first instr_valid 2 cycles after first gnt.
- instr_ready=0 for 10 cycles: FIFO holds 2 entries (pc 0, 2); imem_req stays 0 once full. Ready=1: pc 0 then 2 in order, then fetch resumes at addr 4.
- imem_gnt=0 for 5 cycles: imem_req=1 and imem_addr=0x0006 constant throughout; one fetch completes after gnt.
- redirect=1, redirect_pc=0x0043 while in WAIT: stale rvalid data (0xDEAD) never appears; next imem_addr=0x0042; instr_valid=0 until the 0x0042 data returns.
- redirect coincident with a pop and a push on a full FIFO: next cycle instr_valid=0, FIFO empty, imem_req=1 at the redirect address.
- rst_n low mid-WAIT: outputs take reset values asynchronously. After release, imem_req=1 with imem_addr=RESET_PC; the late rvalid from before reset is ignored.
